// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: credit-limited valid/ready request port to
// instruction memory, a DEPTH-entry show-ahead queue of {instr, pc} pairs
// feeding decode, and redirect handling that flushes the queue and discards
// responses still in flight.
module riscv_fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [XLEN-1:0]            imem_rsp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [XLEN-1:0]            instr,
    output logic [XLEN-1:0]            instr_pc,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     fq_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            deq;
    logic [XLEN-1:0] redirect_tgt;
    logic [CW:0]     occupied;

    // Every accepted request owns a queue slot until its response is consumed
    // or dropped, so a write can never find the queue full.
    assign occupied  = {1'b0, count} + {1'b0, inflight};
    assign credit_ok = occupied < (CW+1)'(DEPTH);

    // Held low during reset so the request port reads idle while reset is high.
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop != '0);
    assign rsp_keep = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign deq      = (count != '0) && instr_ready && !redirect_valid;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    assign instr_valid = (count != '0);
    assign instr       = q_data[head];
    assign instr_pc    = q_pc[head];
    assign fq_count    = count;

    // Fetch PC, response PC, queue pointers and credit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            // Anything still outstanding after this cycle is stale.
            pc_q     <= redirect_tgt;
            rsp_pc   <= redirect_tgt;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= inflight - CW'(imem_rsp_valid);
            drop     <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + XLEN'(4);
            end
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            drop     <= drop - CW'(rsp_drop);
            if (rsp_keep) begin
                tail   <= tail + PW'(1);
                rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(rsp_keep) - CW'(deq);
        end
    end

    // Queue storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (rsp_keep) begin
            q_data[tail] <= imem_rsp_data;
            q_pc[tail]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue with a fixed-latency in-order memory
// model. Inputs change and outputs are sampled around the falling edge.
module tb_riscv_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fq_count;

    int total = 0;
    int bad   = 0;

    int          cyc;
    int          lat;
    int          n_req;
    int          n_deliv;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_count       (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_rsp();
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    // One clock: record accepted request and checked delivery, then advance.
    task automatic step();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            n_req++;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            chk("deliver_pc", instr_pc, exp_pc);
            chk("deliver_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_rsp();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        pend_addr.delete();
        pend_due.delete();
        cyc     = 0;
        n_req   = 0;
        n_deliv = 0;
        exp_pc  = 32'h0;
        reset   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        lat            = 1;
        #3;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fq_count", 32'(fq_count), 32'd0);

        // Zero-wait memory, decode always ready.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 22; i++) step();
        chk("t1_throughput", 32'(n_deliv), 32'd20);

        // Decode stalled for 20 cycles, then released.
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("t2_req_count", 32'(n_req), 32'd4);
        chk("t2_fq_count", 32'(fq_count), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        n_deliv = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t2_drain", 32'(n_deliv), 32'd10);

        // 3-cycle memory, two requests in flight, redirect to 0x100.
        do_reset();
        lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        exp_pc = 32'h100;
        #1;
        chk("t3_fq_count", 32'(fq_count), 32'd0);
        chk("t3_instr_valid", 32'(instr_valid), 32'd0);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk("t3_first_valid", 32'(instr_valid), 32'd1);
        chk("t3_first_pc", instr_pc, 32'h100);
        for (int i = 0; i < 3; i++) step();

        // Redirect in the same cycle as a response and a dequeue.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t4_pre_rsp", 32'(imem_rsp_valid), 32'd1);
        chk("t4_pre_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        chk("t4_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'h200;
        n_deliv = 0;
        #1;
        chk("t4_fq_count", 32'(fq_count), 32'd0);
        chk("t4_instr_valid", 32'(instr_valid), 32'd0);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("t4_deliv", 32'(n_deliv), 32'd3);

        // Request held while memory is not ready.
        do_reset();
        lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("t5_hold_addr", imem_req_addr, 32'h0);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #1;
        chk("t5_one_req", 32'(n_req), 32'd1);
        chk("t5_next_addr", imem_req_addr, 32'h4);
        step();
        step();

        // Asynchronous reset with 3 queued and 1 in flight.
        do_reset();
        lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("t6_pre_count", 32'(fq_count), 32'd3);
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_req_addr", imem_req_addr, 32'h0);
        chk("t6_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_instr_pc", instr_pc, 32'h0);
        chk("t6_fq_count", 32'(fq_count), 32'd0);
        do_reset();
        #1;
        chk("t6_post_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_post_addr", imem_req_addr, 32'h0);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_deliv", 32'(n_deliv), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_queue.md
Name: riscv_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core.
- Replaces the fixed single-cycle PC/InstrF coupling with a valid/ready request port to instruction memory, which may have variable latency.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue that feeds the decode stage.
- Handles branch/jump redirects: flushes the queue and discards responses that are still in flight.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- imem_req_valid  output  1  fetch request is valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  fetch address; always word aligned.
- imem_rsp_valid  input  1  one-cycle response pulse; responses return in order and cannot be back-pressured.
- imem_rsp_data  input  XLEN  returned instruction.
- instr_valid  output  1  queue head is valid.
- instr_ready  input  1  decode accepts the head (deassert to stall).
- instr  output  XLEN  head instruction.
- instr_pc  output  XLEN  PC of the head instruction.
- redirect_valid  input  1  flush and refetch.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] are ignored and treated as 00.
- fq_count  output  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- State:
  - pc_q: next address to request.
  - rsp_pc: PC of the next expected response.
  - count: queue occupancy, 0..DEPTH.
  - inflight: accepted requests not yet responded to, 0..DEPTH.
  - drop: responses still to be discarded, never more than inflight.
- Reset values:
  - pc_q = rsp_pc = RESET_PC.
  - count = inflight = drop = 0.
  - imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0, fq_count = 0.
  - A reset asserted mid-operation aborts everything immediately. Responses that arrive after reset deasserts are not specially handled; the memory must also be reset.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + inflight < DEPTH).
  - imem_req_addr = pc_q.
  - On valid && ready: pc_q += 4 (wraps modulo 2^XLEN) and inflight += 1.
  - The request must stay stable while valid && !ready, except when a redirect withdraws it.
- Response:
  - Every imem_rsp_valid pulse decrements inflight.
  - If drop > 0: the data is discarded and drop -= 1.
  - Otherwise: {imem_rsp_data, rsp_pc} is written to the queue tail, then rsp_pc += 4 and count += 1.
  - A queue write is visible on the outputs the next cycle (rsp to instr_valid latency is 1 cycle). There is no bypass.
- Output side:
  - Show-ahead FIFO: instr_valid = (count != 0); instr and instr_pc come from the head entry.
  - instr_valid && instr_ready dequeues the head.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Overflow is impossible by construction because the credit check reserves a slot for every in-flight request.
  - Empty queue: instr_valid = 0 and instr_ready is ignored.
- Redirect (highest priority):
  - In the cycle redirect_valid is high, no request is issued, no dequeue occurs, and a response arriving that cycle is dropped.
  - Next state:
    - count = 0; head/tail pointers cleared.
    - pc_q = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
    - drop = inflight - (imem_rsp_valid ? 1 : 0), with inflight updated likewise.
  - Back-to-back redirects: each one reloads the PCs. drop accumulates correctly because it always equals the number of outstanding stale responses.
- Credit accounting counts dropped in-flight requests too. This is conservative and intentional: it keeps inflight ≤ DEPTH.
- All counters are sized to hold the value DEPTH without overflow.

Test Plan:
- Zero-wait memory (req_ready = 1, response 1 cycle later), decode always ready, RESET_PC = 0 -> instr_pc sequence 0x0, 0x4, 0x8, …; steady state delivers 1 instruction/cycle; instr matches the memory contents.
- Decode stalled (instr_ready = 0) for 20 cycles, DEPTH = 4 -> exactly 4 requests issued; fq_count = 4; imem_req_valid = 0; after release, entries 0x0..0xC drain in order with no loss.
- Memory with 3-cycle latency, 2 requests in flight, redirect to 0x100 -> the 2 stale responses are dropped; the first instr_valid shows instr_pc = 0x100; fq_count = 0 in the cycle after the redirect.
- Redirect coincident with a response and a dequeue, with redirect_pc = 0x203 -> the response is discarded; the next request address is 0x200; the queue is empty.
- req_ready held low for 5 cycles -> imem_req_addr stays stable at 0x0 with valid high; a single request is accepted when ready rises.
- Reset asserted while 3 entries are queued and 1 request is in flight -> all outputs are 0 asynchronously; after release, the first request address is RESET_PC.
